decode_stage: RTL and testbench
===============================

# decode_stage

Single-entry decode stage of the emulator core, sitting directly upstream of the register file. It accepts fetched instructions over a valid/ready handshake and splits each one into opcode, `rs`/`rt`/`rd` register addresses and a write enable. It tracks in-flight writes to the `rd` bank (regs 8–11) with a scoreboard and stalls read-after-write and write-after-write hazards. It also stops the front end on HALT.

## Interface
- `INSTR_W`, 12: instruction width; fields are `[11:8]` opcode, `[7:4]` rs, `[3:2]` rt, `[1:0]` rd.
- `PC_W`, 8: program counter width.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous kill of the held instruction.
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: stage accepts this cycle.
- `in_instr` input INSTR_W: instruction word.
- `in_pc` input PC_W: PC of `in_instr`.
- `out_valid` output 1: decoded instruction is issuable (held and hazard-free).
- `out_ready` input 1: downstream accepts.
- `out_opcode` output 4: opcode field.
- `out_rs_addr` output 4: register-file `rs_addr` (0–15).
- `out_rt_addr` output 2: register-file `rt_addr` (selects regs 4–7).
- `out_rd_addr` output 2: register-file `rd_addr` (selects regs 8–11).
- `out_write` output 1: instruction writes `rd`.
- `out_pc` output PC_W: PC of the held instruction.
- `wb_valid` input 1: a write to the `rd` bank completes this cycle.
- `wb_rd` input 2: `rd` index of that write.
- `halted` output 1: HALT has issued.
- `stall_cnt` output 16: saturating count of hazard-stall cycles.

## Operation
- **Opcode classes**
  - `4'h0` NOP: no write.
  - `4'h1`–`4'h9` ALU: write.
  - `4'hA` STORE: no write.
  - `4'hB` LOAD: write.
  - `4'hC` BRANCH: no write.
  - `4'hF` HALT: no write.
  - All other opcodes decode as NOP.
- **Holding register**: one entry (`hold_valid`, instruction, PC). All `out_*` fields are decoded combinationally from the held entry.
- **Scoreboard**: `pending[3:0]`, one bit per `rd` index.
  - `pend_eff[r] = pending[r] & ~(wb_valid && wb_rd==r)`. A same-cycle writeback unblocks the stall.
  - RAW hazard: `rs >= 8 && pend_eff[rs-8]`.
  - WAW hazard: `out_write && pend_eff[rd]`.
  - `rt` addresses regs 4–7, which the `rd` port never writes, so `rt` is never a hazard source.
- `out_valid = hold_valid && !hazard && !flush && state==RUN`.
- **Issue** occurs when `out_valid && out_ready`. If `out_write`, issue sets `pending[rd]`.
  - Writeback clears `pending[wb_rd]`.
  - If issue and writeback hit the same index in one cycle, the set wins.
  - A writeback to a non-pending index is ignored.
- `in_ready = state==RUN && !flush && !(hold_valid && held opcode==HALT) && (!hold_valid || issue)`.
- **Load**: when `in_valid && in_ready`, the holding register loads. Otherwise, issue clears `hold_valid`.
- **States**
  - RUN: if a HALT instruction issues, go to HALTED.
  - HALTED: `halted=1`, `in_ready=0`, `out_valid=0`. Stays until reset; flush has no effect.
- **Flush**: clears `hold_valid` (a held HALT is discarded and the state stays RUN).
  - It does not clear `pending`, because those writes are still in flight.
  - In the flush cycle, nothing is accepted and nothing issues.
- **stall_cnt**: increments each cycle with `hold_valid && hazard && state==RUN`. It saturates at `16'hFFFF`.

## Timing
- **Reset values**: `hold_valid=0`, `pending=0`, state RUN, `stall_cnt=0`.
  - Outputs: `out_valid=0`, `halted=0`, all `out_*` fields 0.
  - `in_ready=1` in the first cycle after reset deassertion.
- **Latency**: an instruction accepted at edge N presents `out_valid` in cycle N+1 when hazard-free.
- **Throughput**: one instruction per cycle with `out_ready=1` and no hazards. Accept and issue may occur in the same cycle.
- **Handshake rules**
  - `out_*` fields hold stable while `out_valid && !out_ready`.
  - `out_valid` may drop only because of flush, or rise when a hazard clears.
- **Writeback timing**: a writeback at edge N unblocks a stalled reader in the same cycle N (via `pend_eff`). The register file writes `rd` at that edge, so the downstream read in N+1 sees the new value.
- **Reset mid-operation**: asserting `rst_n` low clears everything immediately, including in-flight pending bits.

## Structure
- Package `emu_pkg`:
  - opcode enum
  - field position constants
  - `RT_BASE=4`, `RD_BASE=8`
  - function `op_writes(opcode)`
  - state enum {RUN, HALTED}
- Sub-module `scoreboard`: the `pending` vector, set/clear logic and `pend_eff`. It is instantiated once.

## Test plan
- **RAW stall**: `12'h196` (ADD rs=9 rt=1 rd=2) then `12'h1A3` (rs=10 rd=3) with `out_ready=1`.
  - Second instruction is held with `out_valid=0` and `stall_cnt` increments.
  - When `wb_valid=1, wb_rd=2`, it issues that same cycle.
- **Back-to-back**: NOPs `12'h000` every cycle, `out_ready=1`.
  - `out_valid` is continuous, one issue per cycle, 1-cycle latency, `stall_cnt=0`.
- **Backpressure**: `out_ready=0` for 3 cycles while holding `12'h1B0`.
  - `out_*` stay stable and `in_ready=0`.
  - On release, it issues and `pending[0]` sets.
- **Same-cycle set/clear**: issue a write to rd=1 while `wb_valid=1, wb_rd=1`.
  - `pending[1]=1` afterwards.
- **HALT**: `12'hF00` accepted.
  - `in_ready=0` while held. After issue, `halted=1` and `out_valid=0`.
  - Later `in_valid` and `flush` are ignored until `rst_n` pulses.
- **Flush and reset**:
  - Flush with `12'h196` held and `pending[2]=1`: `out_valid=0` next cycle and `pending` unchanged.
  - Async reset mid-stall clears `pending`, `stall_cnt`, and all outputs.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions for the emulator core: opcode classes, field
// positions, register-bank bases and the decode-stage state encoding.
package emu_pkg;

   localparam int OP_HI = 11;
   localparam int OP_LO = 8;
   localparam int RS_HI = 7;
   localparam int RS_LO = 4;
   localparam int RT_HI = 3;
   localparam int RT_LO = 2;
   localparam int RD_HI = 1;
   localparam int RD_LO = 0;

   localparam int RT_BASE = 4;
   localparam int RD_BASE = 8;

   typedef enum logic [3:0] {
      OP_NOP     = 4'h0,
      OP_ALU_LO  = 4'h1,
      OP_ALU_HI  = 4'h9,
      OP_STORE   = 4'hA,
      OP_LOAD    = 4'hB,
      OP_BRANCH  = 4'hC,
      OP_HALT    = 4'hF
   } opcode_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_e;

   // ALU ops and LOAD are the only instructions that write the rd bank.
   function automatic logic op_writes(input logic [3:0] opcode);
      return ((opcode >= OP_ALU_LO) && (opcode <= OP_ALU_HI)) || (opcode == OP_LOAD);
   endfunction

endpackage

// File: rtl/decode_stage_scoreboard.sv
// In-flight write tracker for the rd bank (regs 8-11). A same-cycle
// writeback is folded into pend_eff so a stalled reader can issue at once.
module scoreboard (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_en,
   input  logic [1:0] set_idx,
   input  logic       clr_en,
   input  logic [1:0] clr_idx,
   output logic [3:0] pend_eff
);

   logic [3:0] pending_q;
   logic [3:0] pending_d;
   logic [3:0] clr_mask;

   always_comb begin
      clr_mask = 4'b0000;
      if (clr_en) begin
         clr_mask[clr_idx] = 1'b1;
      end
   end

   assign pend_eff = pending_q & ~clr_mask;

   // Clear first so that an issue to the same index in this cycle wins.
   always_comb begin
      pending_d = pending_q & ~clr_mask;
      if (set_en) begin
         pending_d[set_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= 4'b0000;
      end else begin
         pending_q <= pending_d;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Single-entry decode stage: holds one fetched instruction, splits it into
// register-file fields, stalls rd-bank RAW/WAW hazards and stops on HALT.
module decode_stage
   import emu_pkg::*;
#(
   parameter int INSTR_W = 12,
   parameter int PC_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3:0]         out_opcode,
   output logic [3:0]         out_rs_addr,
   output logic [1:0]         out_rt_addr,
   output logic [1:0]         out_rd_addr,
   output logic               out_write,
   output logic [PC_W-1:0]    out_pc,
   input  logic               wb_valid,
   input  logic [1:0]         wb_rd,
   output logic               halted,
   output logic [15:0]        stall_cnt
);

   localparam logic S_RUN    = logic'(ST_RUN);
   localparam logic S_HALTED = logic'(ST_HALTED);

   logic               hold_valid_q, hold_valid_d;
   logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
   logic [PC_W-1:0]    hold_pc_q, hold_pc_d;
   logic               state_q, state_d;
   logic [15:0]        stall_cnt_q, stall_cnt_d;

   logic [3:0] pend_eff;
   logic       run;
   logic       raw_hazard;
   logic       waw_hazard;
   logic       hazard;
   logic       issue;
   logic       accept;
   logic       held_halt;

   assign out_opcode  = hold_instr_q[OP_HI:OP_LO];
   assign out_rs_addr = hold_instr_q[RS_HI:RS_LO];
   assign out_rt_addr = hold_instr_q[RT_HI:RT_LO];
   assign out_rd_addr = hold_instr_q[RD_HI:RD_LO];
   assign out_write   = op_writes(out_opcode);
   assign out_pc      = hold_pc_q;

   // Only rs values 8-11 map onto the tracked rd bank; 12-15 never stall.
   assign raw_hazard = (out_rs_addr[3:2] == 2'b10) && pend_eff[out_rs_addr[1:0]];
   assign waw_hazard = out_write && pend_eff[out_rd_addr];
   assign hazard     = raw_hazard || waw_hazard;

   assign run       = (state_q == S_RUN);
   assign held_halt = hold_valid_q && (out_opcode == OP_HALT);
   assign out_valid = hold_valid_q && !hazard && !flush && run;
   assign issue     = out_valid && out_ready;
   assign in_ready  = run && !flush && !held_halt && (!hold_valid_q || issue);
   assign accept    = in_valid && in_ready;
   assign halted    = (state_q == S_HALTED);
   assign stall_cnt = stall_cnt_q;

   scoreboard u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (issue && out_write),
      .set_idx  (out_rd_addr),
      .clr_en   (wb_valid),
      .clr_idx  (wb_rd),
      .pend_eff (pend_eff)
   );

   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      if (flush && run) begin
         hold_valid_d = 1'b0;
      end else if (accept) begin
         hold_valid_d = 1'b1;
         hold_instr_d = in_instr;
         hold_pc_d    = in_pc;
      end else if (issue) begin
         hold_valid_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      if (run && issue && (out_opcode == OP_HALT)) begin
         state_d = S_HALTED;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hold_valid_q && hazard && run && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid_q <= 1'b0;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
         state_q      <= S_RUN;
         stall_cnt_q  <= 16'd0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         state_q      <= state_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hazards, throughput, backpressure,
// scoreboard set/clear priority, HALT, flush and asynchronous reset.
module tb_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_instr;
   logic [7:0]  in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_opcode;
   logic [3:0]  out_rs_addr;
   logic [1:0]  out_rt_addr;
   logic [1:0]  out_rd_addr;
   logic        out_write;
   logic [7:0]  out_pc;
   logic        wb_valid;
   logic [1:0]  wb_rd;
   logic        halted;
   logic [15:0] stall_cnt;

   int total;
   int bad;

   decode_stage #(.INSTR_W(12), .PC_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_opcode  (out_opcode),
      .out_rs_addr (out_rs_addr),
      .out_rt_addr (out_rt_addr),
      .out_rd_addr (out_rd_addr),
      .out_write   (out_write),
      .out_pc      (out_pc),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .halted      (halted),
      .stall_cnt   (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      out_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0;
      step(); step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%0h exp=0", halted); end
      total++; if (out_opcode !== 4'h0) begin bad++; $display("FAIL rst_opcode got=%0h exp=0", out_opcode); end
      total++; if (out_rs_addr !== 4'h0) begin bad++; $display("FAIL rst_rs got=%0h exp=0", out_rs_addr); end
      total++; if (out_pc !== 8'h00) begin bad++; $display("FAIL rst_pc got=%0h exp=0", out_pc); end
      total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", stall_cnt); end
      rst_n = 1'b1;
      step();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
   endtask

   task automatic test_raw_stall;
      out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 12'h196; in_pc = 8'h10;
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL raw_first_valid got=%0h exp=1", out_valid); end
      total++; if (out_opcode !== 4'h1) begin bad++; $display("FAIL raw_opcode got=%0h exp=1", out_opcode); end
      total++; if (out_rs_addr !== 4'h9) begin bad++; $display("FAIL raw_rs got=%0h exp=9", out_rs_addr); end
      total++; if (out_rt_addr !== 2'h1) begin bad++; $display("FAIL raw_rt got=%0h exp=1", out_rt_addr); end
      total++; if (out_rd_addr !== 2'h2) begin bad++; $display("FAIL raw_rd got=%0h exp=2", out_rd_addr); end
      total++; if (out_write !== 1'b1) begin bad++; $display("FAIL raw_write got=%0h exp=1", out_write); end
      total++; if (out_pc !== 8'h10) begin bad++; $display("FAIL raw_pc got=%0h exp=10", out_pc); end
      in_instr = 12'h1A3; in_pc = 8'h11;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL raw_accept_issue got=%0h exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL raw_stalled got=%0h exp=0", out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL raw_stall_in_ready got=%0h exp=0", in_ready); end
      total++; if (out_pc !== 8'h11) begin bad++; $display("FAIL raw_held_pc got=%0h exp=11", out_pc); end
      step();
      total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL raw_stall_cnt got=%0h exp=1", stall_cnt); end
      wb_valid = 1'b1; wb_rd = 2'd2;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL raw_wb_unblock got=%0h exp=1", out_valid); end
      step();
      wb_rd = 2'd3;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL raw_after_issue got=%0h exp=0", out_valid); end
      total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL raw_stall_hold got=%0h exp=1", stall_cnt); end
      step();
      wb_valid = 1'b0;
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 12'h000;
      for (int i = 0; i < 6; i++) begin
         in_pc = 8'h50 + 8'(i);
         step();
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%0h exp=1", i, out_valid); end
         total++; if (out_pc !== 8'h50 + 8'(i)) begin bad++; $display("FAIL b2b_pc[%0d] got=%0h exp=%0h", i, out_pc, 8'h50 + 8'(i)); end
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%0h exp=1", i, in_ready); end
      end
      in_valid = 1'b0;
      step();
      total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL b2b_stall got=%0h exp=1", stall_cnt); end
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 12'h1B0; in_pc = 8'h20;
      step();
      in_instr = 12'h000; in_pc = 8'h21;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%0h exp=1", i, out_valid); end
         total++; if (out_opcode !== 4'h1 || out_rs_addr !== 4'hB || out_rd_addr !== 2'h0) begin
            bad++; $display("FAIL bp_fields[%0d] got=%0h/%0h/%0h exp=1/b/0", i, out_opcode, out_rs_addr, out_rd_addr);
         end
         total++; if (out_pc !== 8'h20) begin bad++; $display("FAIL bp_pc[%0d] got=%0h exp=20", i, out_pc); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%0h exp=0", i, in_ready); end
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_release got=%0h exp=1", out_valid); end
      step();
      // Same rd again: must stall on pending[0] set by the release issue.
      in_valid = 1'b1; in_instr = 12'h1B0; in_pc = 8'h22;
      step();
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_waw_stall got=%0h exp=0", out_valid); end
      step();
      total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL bp_stall_cnt got=%0h exp=2", stall_cnt); end
      wb_valid = 1'b1; wb_rd = 2'd0;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_waw_clear got=%0h exp=1", out_valid); end
      step();
      step();
      wb_valid = 1'b0;
   endtask

   task automatic test_same_cycle;
      out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 12'h101; in_pc = 8'h30;
      step();
      in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 2'd1;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sc_issue got=%0h exp=1", out_valid); end
      step();
      wb_valid = 1'b0;
      in_valid = 1'b1; in_instr = 12'h090; in_pc = 8'h31;
      step();
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sc_set_wins got=%0h exp=0", out_valid); end
      step();
      total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL sc_stall_cnt got=%0h exp=3", stall_cnt); end
      wb_valid = 1'b1; wb_rd = 2'd1;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sc_unblock got=%0h exp=1", out_valid); end
      step();
      wb_valid = 1'b0;
   endtask

   task automatic test_flush;
      out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 12'h102; in_pc = 8'h60;
      step();
      in_instr = 12'h196; in_pc = 8'h61;
      step();
      in_valid = 1'b0; flush = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%0h exp=0", out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_in_ready got=%0h exp=0", in_ready); end
      step();
      flush = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_after_valid got=%0h exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_after_ready got=%0h exp=1", in_ready); end
      total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL fl_stall_cnt got=%0h exp=4", stall_cnt); end
      in_valid = 1'b1; in_instr = 12'h0A0; in_pc = 8'h62;
      step();
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_pending_kept got=%0h exp=0", out_valid); end
      wb_valid = 1'b1; wb_rd = 2'd2;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fl_wb_unblock got=%0h exp=1", out_valid); end
      step();
      wb_valid = 1'b0;
   endtask

   task automatic test_halt;
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 12'hF00; in_pc = 8'h40;
      step();
      in_instr = 12'h000; in_pc = 8'h41;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ht_in_ready got=%0h exp=0", in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ht_valid got=%0h exp=1", out_valid); end
      total++; if (out_opcode !== 4'hF || out_write !== 1'b0) begin bad++; $display("FAIL ht_decode got=%0h/%0h exp=f/0", out_opcode, out_write); end
      step();
      total++; if (out_pc !== 8'h40) begin bad++; $display("FAIL ht_pc got=%0h exp=40", out_pc); end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL ht_halted got=%0h exp=1", halted); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ht_out_valid got=%0h exp=0", out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ht_in_ready2 got=%0h exp=0", in_ready); end
      in_valid = 1'b1; flush = 1'b1;
      step(); step();
      in_valid = 1'b0; flush = 1'b0;
      #1;
      total++; if (halted !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL ht_sticky got=%0h/%0h exp=1/0", halted, out_valid); end
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      #1;
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL ht_reset got=%0h exp=0", halted); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ht_reset_ready got=%0h exp=1", in_ready); end
   endtask

   task automatic test_reset_mid_stall;
      out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 12'h103; in_pc = 8'h70;
      step();
      in_instr = 12'h0B0; in_pc = 8'h71;
      step();
      in_valid = 1'b0;
      step(); step();
      total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL mr_stall_cnt got=%0h exp=2", stall_cnt); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mr_stalled got=%0h exp=0", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL mr_stall_clr got=%0h exp=0", stall_cnt); end
      total++; if (out_opcode !== 4'h0 || out_rs_addr !== 4'h0 || out_pc !== 8'h00) begin
         bad++; $display("FAIL mr_fields got=%0h/%0h/%0h exp=0/0/0", out_opcode, out_rs_addr, out_pc);
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mr_out_valid got=%0h exp=0", out_valid); end
      #2 rst_n = 1'b1;
      in_valid = 1'b1; in_instr = 12'h0B0; in_pc = 8'h72;
      step();
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mr_pending_clr got=%0h exp=1", out_valid); end
      step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_raw_stall();
      test_back_to_back();
      test_backpressure();
      test_same_cycle();
      test_flush();
      test_halt();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
